// File: rtl/juice_pkg.sv
// Shared types and default timing for the juice dispense responder.
package juice_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN_1,
        RUN_2,
        WAIT_DROP,
        CHANGE,
        DONE,
        FAULT
    } state_t;

    localparam int MOTOR_CYCLES_DEF  = 16;
    localparam int DROP_TIMEOUT_DEF  = 64;
    localparam int CHANGE_CYCLES_DEF = 4;

    // Width of the one shared down-counter that times every phase.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/juice_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
module juice_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/juice_dispense_ctrl.sv
// Vend responder: turns juice/change request edges into timed actuator pulses,
// confirms cup delivery on the drop sensor and reports done/fault upstream.
module juice_dispense_ctrl
    import juice_pkg::*;
#(
    parameter int MOTOR_CYCLES  = MOTOR_CYCLES_DEF,
    parameter int DROP_TIMEOUT  = DROP_TIMEOUT_DEF,
    parameter int CHANGE_CYCLES = CHANGE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic vend_j1,
    input  logic vend_j2,
    input  logic vend_change,
    input  logic drop_sensor,
    input  logic fault_clr,
    output logic motor_1,
    output logic motor_2,
    output logic change_pulse,
    output logic busy,
    output logic done,
    output logic fault
);

    localparam int CW = cnt_width(MOTOR_CYCLES, DROP_TIMEOUT, CHANGE_CYCLES);
    localparam logic [CW-1:0] MOTOR_LOAD  = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] DROP_LOAD   = CW'(DROP_TIMEOUT - 1);
    localparam logic [CW-1:0] CHANGE_LOAD = CW'(CHANGE_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          drop_seen;
    logic          hist_j1, hist_j2, hist_ch;
    logic          drop_sync, drop_q, drop_rise;
    logic          edge_j1, edge_j2, edge_ch;

    juice_sync2 u_drop_sync (
        .clk (clk),
        .rst (rst),
        .d   (drop_sensor),
        .q   (drop_sync)
    );

    // History resets high so a request held across reset release needs a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_j1 <= 1'b1;
            hist_j2 <= 1'b1;
            hist_ch <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            hist_j1 <= vend_j1;
            hist_j2 <= vend_j2;
            hist_ch <= vend_change;
            drop_q  <= drop_sync;
        end
    end

    assign edge_j1   = vend_j1 & ~hist_j1;
    assign edge_j2   = vend_j2 & ~hist_j2;
    assign edge_ch   = vend_change & ~hist_ch;
    assign drop_rise = drop_sync & ~drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            drop_seen    <= 1'b0;
            motor_1      <= 1'b0;
            motor_2      <= 1'b0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_j1) begin
                        state   <= RUN_1;
                        motor_1 <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= MOTOR_LOAD;
                    end else if (edge_j2) begin
                        state   <= RUN_2;
                        motor_2 <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= MOTOR_LOAD;
                    end else if (edge_ch) begin
                        state        <= CHANGE;
                        change_pulse <= 1'b1;
                        busy         <= 1'b1;
                        cnt          <= CHANGE_LOAD;
                    end
                end
                RUN_1, RUN_2: begin
                    if (drop_rise) drop_seen <= 1'b1;
                    if (cnt == '0) begin
                        motor_1 <= 1'b0;
                        motor_2 <= 1'b0;
                        // A drop landing on the final motor cycle still counts as delivered.
                        if (drop_seen || drop_rise) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_DROP;
                            cnt   <= DROP_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_DROP: begin
                    if (drop_rise) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHANGE: begin
                    if (cnt == '0) begin
                        change_pulse <= 1'b0;
                        state        <= DONE;
                        done         <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    drop_seen <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    drop_seen    <= 1'b0;
                    motor_1      <= 1'b0;
                    motor_2      <= 1'b0;
                    change_pulse <= 1'b0;
                    busy         <= 1'b0;
                    fault        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_juice_dispense_ctrl.sv
// Self-checking bench for juice_dispense_ctrl: vector table, corner sequences, random vs timeline model.
module tb_juice_dispense_ctrl;

    localparam int MC = 16;
    localparam int DT = 64;
    localparam int CC = 4;

    // Output vector order: {motor_1, motor_2, change_pulse, busy, done, fault}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_M1   = 6'b100100;
    localparam logic [5:0] O_CH   = 6'b001100;
    localparam logic [5:0] O_DN   = 6'b000110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vend_j1 = 1'b0, vend_j2 = 1'b0, vend_change = 1'b0;
    logic drop_sensor = 1'b0, fault_clr = 1'b0;
    logic motor_1, motor_2, change_pulse, busy, done, fault;
    logic [5:0] obs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    juice_dispense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .vend_j1      (vend_j1),
        .vend_j2      (vend_j2),
        .vend_change  (vend_change),
        .drop_sensor  (drop_sensor),
        .fault_clr    (fault_clr),
        .motor_1      (motor_1),
        .motor_2      (motor_2),
        .change_pulse (change_pulse),
        .busy         (busy),
        .done         (done),
        .fault        (fault)
    );

    assign obs = {motor_1, motor_2, change_pulse, busy, done, fault};

    task automatic check(input string name, input int act, input int want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vend_j1 = 1'b0; vend_j2 = 1'b0; vend_change = 1'b0;
        drop_sensor = 1'b0; fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Vector table: inputs held for n cycles, outputs compared every cycle
    typedef struct {
        logic       j1, j2, ch, drop, clr;
        logic [5:0] want;
        int         n;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic j1, j2, ch, drop, clr, input logic [5:0] want, input int n);
        vec_t v;
        v.j1 = j1; v.j2 = j2; v.ch = ch; v.drop = drop; v.clr = clr; v.want = want; v.n = n;
        vecs.push_back(v);
    endtask

    // Timeline reference model: a job starting at edge cycle t0 has its actuator
    // high over t0+1.., and a completion cycle derived from when the drop is seen.
    int m_mode;   // 0 idle, 1 job in progress, 2 fault
    int m_kind;   // 1 juice1, 2 juice2, 3 change
    int m_t0;
    int m_end;    // cycle done is high, -1 while unknown
    bit h1, h2, hc, d1, d2, d3;

    function automatic logic [5:0] model_out(input int c);
        logic [5:0] o;
        o = '0;
        if (m_mode == 1) begin
            o[5] = (m_kind == 1) && (c <= m_t0 + MC);
            o[4] = (m_kind == 2) && (c <= m_t0 + MC);
            o[3] = (m_kind == 3) && (c <= m_t0 + CC);
            o[2] = 1'b1;
            o[1] = (c == m_end);
        end else if (m_mode == 2) begin
            o[0] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_start(input int kind, input int c);
        m_mode = 1; m_kind = kind; m_t0 = c;
        m_end = (kind == 3) ? c + CC + 1 : -1;
    endtask

    task automatic model_step(input int c);
        bit rise, e1, e2, ec;
        rise = d2 & ~d3;   // sensor rise visible to the controller two cycles after it is sampled
        e1 = vend_j1 & ~h1;
        e2 = vend_j2 & ~h2;
        ec = vend_change & ~hc;
        case (m_mode)
            0: begin
                if (e1) model_start(1, c);
                else if (e2) model_start(2, c);
                else if (ec) model_start(3, c);
            end
            1: begin
                if (m_kind != 3 && m_end < 0 && rise)
                    m_end = (c <= m_t0 + MC) ? m_t0 + MC + 1 : c + 1;
                if (m_kind != 3 && m_end < 0 && c == m_t0 + MC + DT) m_mode = 2;
                else if (c == m_end) m_mode = 0;
            end
            default: if (fault_clr) m_mode = 0;
        endcase
        h1 = vend_j1; h2 = vend_j2; hc = vend_change;
        d3 = d2; d2 = d1; d1 = drop_sensor;
    endtask

    // Juice-2 vend with a 2-cycle drop pulse starting drop_k cycles after the edge
    task automatic run_wait(input string name, input int drop_k, input int exp_done);
        int done_at, ndone;
        bit fseen;
        done_at = -1; ndone = 0; fseen = 1'b0;
        vend_j1 = 1'b0; vend_j2 = 1'b0; next();
        vend_j2 = 1'b1;
        for (int k = 0; k <= 90; k++) begin
            drop_sensor = (k == drop_k) || (k == drop_k + 1);
            @(negedge clk);
            if (done) begin done_at = k; ndone++; end
            if (fault) fseen = 1'b1;
            next();
        end
        check({name, " done cycle"}, done_at, exp_done);
        check({name, " done count"}, ndone, int'(exp_done >= 0));
        check({name, " fault"}, int'(fseen), int'(exp_done < 0));
        fault_clr = 1'b1; next();
        fault_clr = 1'b0; next();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int m2cnt, cnt6, dl;

        @(posedge clk); #1;
        check("reset outs", int'(obs), int'(O_IDLE));
        do_reset();

        // 1: j1 held, drop during run, no re-vend
        add(0,0,0,0,0, O_IDLE, 2);
        add(1,0,0,0,0, O_IDLE, 1);
        add(1,0,0,0,0, O_M1, 4);
        add(1,0,0,1,0, O_M1, 2);
        add(1,0,0,0,0, O_M1, 10);
        add(1,0,0,0,0, O_DN, 1);
        add(1,0,0,0,0, O_IDLE, 6);
        // 4: simultaneous edges, j1 wins
        add(0,0,0,0,0, O_IDLE, 2);
        add(1,1,1,0,0, O_IDLE, 1);
        add(1,1,1,0,0, O_M1, 3);
        add(1,1,1,1,0, O_M1, 1);
        add(1,1,1,0,0, O_M1, 12);
        add(1,1,1,0,0, O_DN, 1);
        add(1,1,1,0,0, O_IDLE, 6);
        // 5: change request, j1 edge while busy dropped, stray fault_clr harmless
        add(0,0,0,0,0, O_IDLE, 2);
        add(0,0,1,0,0, O_IDLE, 1);
        add(0,0,1,0,0, O_CH, 1);
        add(1,0,1,0,0, O_CH, 3);
        add(1,0,1,0,0, O_DN, 1);
        add(1,0,1,0,1, O_IDLE, 6);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                vend_j1 = vecs[i].j1; vend_j2 = vecs[i].j2; vend_change = vecs[i].ch;
                drop_sensor = vecs[i].drop; fault_clr = vecs[i].clr;
                @(negedge clk);
                check($sformatf("vec%0d.%0d", i, k), int'(obs), int'(vecs[i].want));
                next();
            end
        end

        // 2: no drop -> timeout fault, requests ignored in fault, fault_clr recovers
        vend_j1 = 0; vend_j2 = 0; vend_change = 0; drop_sensor = 0; fault_clr = 0;
        next();
        vend_j2 = 1'b1;
        m2cnt = 0;
        for (int k = 0; k <= 81; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= MC && motor_2) m2cnt++;
            if (k == MC + 1) check("t2 motor off", int'(motor_2), 0);
            if (k == MC + DT) check("t2 pre-expiry", int'({fault, busy}), 1);
            if (k == MC + DT + 1) check("t2 fault", int'({fault, busy}), 2);
            next();
        end
        check("t2 motor cycles", m2cnt, MC);
        vend_j1 = 1'b1;
        @(negedge clk);
        check("t2 vend in fault", int'({motor_1, fault}), 1);
        next();
        fault_clr = 1'b1;
        @(negedge clk);
        check("t2 fault held", int'(fault), 1);
        next();
        fault_clr = 1'b0;
        @(negedge clk);
        check("t2 cleared", int'(obs), int'(O_IDLE));
        next();

        // 3: drop in wait window, on the expiry cycle, and just after expiry
        run_wait("t3 wait10", 27, 30);
        run_wait("t3 expiry", 78, 81);
        run_wait("t3 late", 79, -1);

        // 6: request held through reset release, then async reset mid-run
        rst = 1'b1; vend_j1 = 1'b1; vend_j2 = 0; vend_change = 0; drop_sensor = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cnt6 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (motor_1 || busy) cnt6++;
            next();
        end
        check("t6 held through reset", cnt6, 0);
        vend_j1 = 1'b0; next();
        vend_j1 = 1'b1;
        repeat (5) next();
        check("t6 running", int'(motor_1), 1);
        #1 rst = 1'b1;
        #1 check("t6 async motor off", int'({motor_1, busy}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; vend_j1 = 1'b0;
        cnt6 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || motor_1) cnt6++;
            next();
        end
        check("t6 no done after reset", cnt6, 0);

        // Random stimulus against the timeline model
        do_reset();
        m_mode = 0; m_kind = 0; m_t0 = 0; m_end = -1;
        h1 = 1; h2 = 1; hc = 1; d1 = 0; d2 = 0; d3 = 0;
        dl = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                if ($urandom_range(0, 7) == 0) vend_j1 = ~vend_j1;
                if ($urandom_range(0, 7) == 0) vend_j2 = ~vend_j2;
                if ($urandom_range(0, 9) == 0) vend_change = ~vend_change;
                if (dl == 0 && $urandom_range(0, 39) == 0) dl = int'($urandom_range(1, 4));
                drop_sensor = (dl > 0);
                if (dl > 0) dl--;
                fault_clr = ($urandom_range(0, 15) == 0);
            end
            @(negedge clk);
            check($sformatf("rand c%0d", c), int'(obs), int'(model_out(c)));
            model_step(c);
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
